// File: rtl/ahb_pkg.sv
// AHB transfer-type encodings used by every block that observes HTRANS.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
endpackage

// File: rtl/aidc_lite_ahb_arbiter_pkg.sv
// AIDC-Lite arbiter types: ownership FSM states.
package aidc_lite_ahb_arbiter_pkg;
  typedef enum logic [1:0] {
    S_PARK  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } arb_state_t;
endpackage

// File: rtl/aidc_lite_arb_pick.sv
// Combinational winner select over the request mask.
// AIDC_LITE_ARB_RR_EN: round-robin starting after i_last_w; otherwise lowest index wins.
module aidc_lite_arb_pick #(
  parameter int NUM_MST = 2,
  parameter int MW      = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [MW-1:0]      i_last_w,
  output logic [MW-1:0]      o_winner,
  output logic               o_any_req
);
  assign o_any_req = |i_req;

`ifdef AIDC_LITE_ARB_RR_EN
  // Smallest rotational distance from last_w+1 wins.
  always_comb begin
    int dist;
    int best;
    o_winner = '0;
    dist     = 0;
    best     = NUM_MST;
    for (int j = 0; j < NUM_MST; j++) begin
      dist = (j + NUM_MST - 1 - int'(i_last_w)) % NUM_MST;
      if (i_req[j] && (dist < best)) begin
        best     = dist;
        o_winner = MW'(j);
      end
    end
  end
`else
  logic w_unused_last_w;
  assign w_unused_last_w = ^i_last_w;

  always_comb begin
    o_winner = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (i_req[i]) o_winner = MW'(i);
    end
  end
`endif
endmodule

// File: rtl/aidc_lite_ahb_arbiter.sv
// AHB2 arbiter for the shared memory slave; hands over only at INCR burst boundaries.
// AIDC_LITE_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
module aidc_lite_ahb_arbiter
  import ahb_pkg::*;
  import aidc_lite_ahb_arbiter_pkg::*;
#(
  parameter int NUM_MST   = 2,
  parameter int BURST_LEN = 16,
  parameter int WAIT_MAX  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MST-1:0]         hbusreq_i,
  input  logic [1:0]                 htrans_i,
  input  logic                       hready_i,
  output logic [NUM_MST-1:0]         hgrant_o,
  output logic [$clog2(NUM_MST)-1:0] hmaster_o,
  output logic [$clog2(NUM_MST)-1:0] hmaster_data_o,
  output logic                       busy_o
);
  localparam int MW = $clog2(NUM_MST);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int WW = $clog2(WAIT_MAX + 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_MST-1:0] r_grant;
  logic [MW-1:0]      r_master, w_master_nxt, r_master_data;
  logic [BW-1:0]      r_beat_cnt, w_beat_nxt;
  logic [WW-1:0]      r_wait_cnt, w_wait_nxt;
  logic [MW-1:0]      w_winner, w_last_w;
  logic               w_any_req, w_take, w_park, w_end;

`ifdef AIDC_LITE_ARB_RR_EN
  logic [MW-1:0] r_last_w;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last_w <= '0;
    else if (w_take) r_last_w <= w_winner;
  end
  assign w_last_w = r_last_w;
`else
  assign w_last_w = '0;
`endif

  aidc_lite_arb_pick #(.NUM_MST(NUM_MST), .MW(MW)) u_pick (
    .i_req     (hbusreq_i),
    .i_last_w  (w_last_w),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_master_nxt = r_master;
    w_beat_nxt   = r_beat_cnt;
    w_wait_nxt   = r_wait_cnt;
    w_take       = 1'b0;
    w_park       = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      S_PARK: w_take = w_any_req && hready_i;
      S_WAIT: begin
        // Timeout runs on raw cycles so a stalled bus cannot hold a dead grant.
        if (hready_i && (htrans_i == HTRANS_NONSEQ)) begin
          w_state_nxt = S_BURST;
          w_beat_nxt  = BW'(1);
        end else if (r_wait_cnt == WW'(WAIT_MAX)) begin
          w_park = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end
      S_BURST: begin
        if (hready_i) begin
          case (htrans_i)
            HTRANS_SEQ: begin
              if (r_beat_cnt == BW'(BURST_LEN - 1)) w_end = 1'b1;
              else                                  w_beat_nxt = r_beat_cnt + BW'(1);
            end
            HTRANS_BUSY: ;
            default: w_end = 1'b1;
          endcase
        end
        if (w_end) begin
          w_take = w_any_req;
          w_park = !w_any_req;
        end
      end
      default: w_park = 1'b1;
    endcase
    if (w_take) begin
      w_state_nxt  = S_WAIT;
      w_master_nxt = w_winner;
      w_beat_nxt   = '0;
      w_wait_nxt   = '0;
    end
    if (w_park) begin
      w_state_nxt  = S_PARK;
      w_master_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_PARK;
      r_grant       <= NUM_MST'(1);
      r_master      <= '0;
      r_master_data <= '0;
      r_beat_cnt    <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= NUM_MST'(1) << w_master_nxt;
      r_master   <= w_master_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (hready_i) r_master_data <= r_master;
    end
  end

  assign hgrant_o       = r_grant;
  assign hmaster_o      = r_master;
  assign hmaster_data_o = r_master_data;
  assign busy_o         = (r_state != S_PARK);
endmodule
